// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: sequences fetch / decode / execute / memory /
// writeback steps and drives datapath selects and write enables for each step.
//
// Ports
//   clk_i, rst_i        : clock, synchronous active-high reset
//   op_i, funct3_i      : instruction opcode and funct3 fields from IR
//   zero_i, lt_i, ltu_i : ALU flags (equal, signed lt, unsigned lt)
//   mem_ready_i         : memory completes the access this cycle
//   mem_req_o           : memory access request
//   mem_write_o         : access is a store
//   adr_src_o           : memory address select (0 PC, 1 ALUOut)
//   ir_write_o          : IR write enable
//   pc_write_o          : PC write enable
//   reg_write_o         : register-file write enable
//   alu_src_a_o         : ALU A select (00 PC, 01 oldPC, 10 rs1, 11 zero)
//   alu_src_b_o         : ALU B select (00 rs2, 01 imm, 10 const 4)
//   alu_op_o            : 00 add, 01 sub/compare, 10 funct decode
//   result_src_o        : 00 ALUOut, 01 mem read data, 10 ALU result
//   imm_src_o           : immediate format (000 I, 001 B, 010 S, 011 U, 100 J)
//   fault_o, illegal_o  : sticky memory-timeout and illegal-instruction flags
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic [2:0] imm_src_o,
  output logic       fault_o,
  output logic       illegal_o
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JALR     = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_UPPER    = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             illegal_q, illegal_d;

  logic       mem_req_c, mem_write_c, adr_src_c;
  logic       ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, alu_op_c, result_src_c;
  logic       taken_c, branch_bad_c, stall_c, timeout_c;

  // Branch condition from funct3; reserved encodings never take.
  always_comb begin
    taken_c      = 1'b0;
    branch_bad_c = 1'b0;
    case (funct3_i)
      3'b000:  taken_c = zero_i;
      3'b001:  taken_c = ~zero_i;
      3'b100:  taken_c = lt_i;
      3'b101:  taken_c = ~lt_i;
      3'b110:  taken_c = ltu_i;
      3'b111:  taken_c = ~ltu_i;
      default: branch_bad_c = 1'b1;
    endcase
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    imm_src_o = 3'b000;
    case (op_i)
      OP_STORE:         imm_src_o = 3'b010;
      OP_BRANCH:        imm_src_o = 3'b001;
      OP_LUI, OP_AUIPC: imm_src_o = 3'b011;
      OP_JAL:           imm_src_o = 3'b100;
      default:          imm_src_o = 3'b000;
    endcase
  end

  // Per-state datapath controls.
  always_comb begin
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    result_src_c = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        // IR load and PC+4 commit together with the fetch completing.
        ir_write_c   = mem_ready_i;
        pc_write_c   = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_op_c    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b01;
        pc_write_c  = taken_c;
      end
      S_JALR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
      end
      S_JAL: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
      end
      S_UPPER: begin
        // LUI adds imm to zero, AUIPC adds imm to oldPC.
        alu_src_a_c = (op_i == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b_c = 2'b01;
      end
      default: ;
    endcase
  end

  // A stalled cycle is one where the block requests memory and it does not answer.
  assign stall_c   = mem_req_c & ~mem_ready_i;
  assign timeout_c = stall_c && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Next-state and sticky error flags.
  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_OP:             state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
      S_EXEC_R,
      S_EXEC_I,
      S_UPPER:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH: begin
        if (branch_bad_c) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
    if (timeout_c) begin
      state_d = S_HALT;
      fault_d = 1'b1;
    end
  end

  // Wait counter restarts whenever memory answers or the step changes.
  always_comb begin
    cnt_d = cnt_q;
    if (mem_ready_i || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (stall_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      illegal_q <= illegal_d;
    end
  end

  // Write enables are forced low while reset is held.
  assign mem_req_o    = mem_req_c;
  assign mem_write_o  = mem_write_c & ~rst_i;
  assign adr_src_o    = adr_src_c;
  assign ir_write_o   = ir_write_c & ~rst_i;
  assign pc_write_o   = pc_write_c & ~rst_i;
  assign reg_write_o  = reg_write_c & ~rst_i;
  assign alu_src_a_o  = alu_src_a_c;
  assign alu_src_b_o  = alu_src_b_c;
  assign alu_op_o     = alu_op_c;
  assign result_src_o = result_src_c;
  assign fault_o      = fault_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected
// per-cycle control vectors, queued, and compared by an independent monitor.
module tb_multicycle_control;

  localparam int unsigned MEM_TIMEOUT = 15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] alu;
    logic [1:0] res;
    logic [2:0] imm;
    logic       fault;
    logic       illegal;
  } outv_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] op_i = 7'd0;
  logic [2:0] funct3_i = 3'd0;
  logic       zero_i = 1'b0, lt_i = 1'b0, ltu_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
  logic [2:0] imm_src_o;
  logic       fault_o, illegal_o;

  outv_t exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Reference-model state: sticky flags, halted, and the instruction fields held on the bus.
  logic       m_fault = 1'b0, m_illegal = 1'b0, m_halted = 1'b0;
  logic [6:0] cur_op = 7'd0;
  logic [2:0] cur_f3 = 3'd0;
  logic       cur_z = 1'b0, cur_lt = 1'b0, cur_ltu = 1'b0, cur_rst = 1'b1;

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i),
    .zero_i(zero_i), .lt_i(lt_i), .ltu_i(ltu_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .adr_src_o(adr_src_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .result_src_o(result_src_o), .imm_src_o(imm_src_o),
    .fault_o(fault_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == OP_STORE) return 3'b010;
    if (op == OP_BRANCH) return 3'b001;
    if (op == OP_LUI || op == OP_AUIPC) return 3'b011;
    if (op == OP_JAL) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic l, input logic lu);
    case (f3)
      3'b000:  return z;    // beq
      3'b001:  return !z;   // bne
      3'b100:  return l;    // blt
      3'b101:  return !l;   // bge
      3'b110:  return lu;   // bltu
      3'b111:  return !lu;  // bgeu
      default: return 1'b0;
    endcase
  endfunction

  // Everything off: the baseline every step starts from.
  function automatic outv_t blank();
    outv_t e;
    e = '0;
    e.imm = imm_of(cur_op);
    e.fault = m_fault;
    e.illegal = m_illegal;
    return e;
  endfunction

  function automatic outv_t mk(input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] alu, input logic [1:0] res);
    outv_t e;
    e = blank();
    e.a = a; e.b = b; e.alu = alu; e.res = res;
    return e;
  endfunction

  // Drive one cycle of inputs and, if requested, queue what the outputs must be.
  task automatic step(input logic rdy, input outv_t e, input string tag, input bit chk);
    @(posedge clk);
    #1;
    rst_i = cur_rst;
    op_i = cur_op;
    funct3_i = cur_f3;
    zero_i = cur_z;
    lt_i = cur_lt;
    ltu_i = cur_ltu;
    mem_ready_i = rdy;
    if (chk) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) step(rbit(), blank(), "halt", 1'b1);
  endtask

  // A memory access that stalls for the given number of cycles, then completes,
  // unless the stall reaches the timeout, in which case the block halts with a fault.
  task automatic mem_wait(input outv_t busy, input outv_t done, input int stalls, input string tag);
    for (int i = 0; i < stalls; i++) begin
      step(1'b0, busy, tag, 1'b1);
      if (i + 1 == int'(MEM_TIMEOUT)) begin
        m_fault = 1'b1;
        m_halted = 1'b1;
        return;
      end
    end
    step(1'b1, done, tag, 1'b1);
  endtask

  task automatic do_reset();
    outv_t e;
    cur_rst = 1'b1;
    step(1'b1, blank(), "reset0", 1'b0);
    m_fault = 1'b0;
    m_illegal = 1'b0;
    m_halted = 1'b0;
    // In FETCH with memory ready but reset held: no write enable may fire.
    e = mk(2'b00, 2'b10, 2'b00, 2'b10);
    e.mem_req = 1'b1;
    step(1'b1, e, "reset_fetch", 1'b1);
    cur_rst = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input logic l, input logic lu, input int fstall, input int mstall);
    outv_t e, d;
    cur_op = op; cur_f3 = f3; cur_z = z; cur_lt = l; cur_ltu = lu;
    // fetch: PC -> memory, PC+4 computed, IR/PC loaded when memory answers
    e = mk(2'b00, 2'b10, 2'b00, 2'b10);
    e.mem_req = 1'b1;
    d = e; d.ir_write = 1'b1; d.pc_write = 1'b1;
    mem_wait(e, d, fstall, "fetch");
    if (m_halted) return;
    step(rbit(), mk(2'b01, 2'b01, 2'b00, 2'b00), "decode", 1'b1);
    case (op)
      OP_OP, OP_IMM: begin
        step(rbit(), mk(2'b10, (op == OP_OP) ? 2'b00 : 2'b01, 2'b10, 2'b00), "exec", 1'b1);
        e = blank(); e.reg_write = 1'b1;
        step(rbit(), e, "aluwb", 1'b1);
      end
      OP_LOAD, OP_STORE: begin
        step(rbit(), mk(2'b10, 2'b01, 2'b00, 2'b00), "memadr", 1'b1);
        e = blank(); e.mem_req = 1'b1; e.adr_src = 1'b1;
        e.mem_write = (op == OP_STORE);
        mem_wait(e, e, mstall, (op == OP_LOAD) ? "memread" : "memwrite");
        if (!m_halted && op == OP_LOAD) begin
          e = mk(2'b00, 2'b00, 2'b00, 2'b01); e.reg_write = 1'b1;
          step(rbit(), e, "memwb", 1'b1);
        end
      end
      OP_BRANCH: begin
        e = mk(2'b10, 2'b00, 2'b01, 2'b00);
        e.pc_write = taken_of(f3, z, l, lu);
        step(rbit(), e, "branch", 1'b1);
        if (f3 == 3'b010 || f3 == 3'b011) begin
          m_illegal = 1'b1;
          m_halted = 1'b1;
        end
      end
      OP_JAL, OP_JALR: begin
        if (op == OP_JALR) step(rbit(), mk(2'b10, 2'b01, 2'b00, 2'b00), "jalr", 1'b1);
        e = mk(2'b01, 2'b10, 2'b00, 2'b00); e.pc_write = 1'b1;
        step(rbit(), e, "jal", 1'b1);
        e = blank(); e.reg_write = 1'b1;
        step(rbit(), e, "link_wb", 1'b1);
      end
      OP_LUI, OP_AUIPC: begin
        step(rbit(), mk((op == OP_LUI) ? 2'b11 : 2'b01, 2'b01, 2'b00, 2'b00), "upper", 1'b1);
        e = blank(); e.reg_write = 1'b1;
        step(rbit(), e, "aluwb", 1'b1);
      end
      default: begin
        m_illegal = 1'b1;
        m_halted = 1'b1;
      end
    endcase
  endtask

  // After an instruction that halts, confirm the block stays put, then recover via reset.
  task automatic settle();
    if (m_halted) begin
      halt_cycles(4);
      do_reset();
    end
  endtask

  function automatic int rand_stall();
    int k;
    k = int'($urandom_range(0, 39));
    if (k == 0) return int'(MEM_TIMEOUT) + int'($urandom_range(0, 3));
    if (k == 1) return int'(MEM_TIMEOUT) - 1;
    return int'($urandom_range(0, 3));
  endfunction

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 19))
      0, 1, 2:  return OP_OP;
      3, 4:     return OP_IMM;
      5, 6:     return OP_LOAD;
      7, 8:     return OP_STORE;
      9, 10, 11: return OP_BRANCH;
      12, 13:   return OP_JAL;
      14, 15:   return OP_JALR;
      16:       return OP_LUI;
      17:       return OP_AUIPC;
      18:       return OP_BAD;
      default:  return 7'b0000000;
    endcase
  endfunction

  // Monitor: compares every cycle that has a queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outv_t e, act;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act = '{mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
              alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, imm_src_o, fault_o, illegal_o};
      n_checks++;
      if (act !== e) begin
        n_errors++;
        $display("FAIL %s t=%0t op=%b f3=%b actual=%b required=%b (req,wr,adr,ir,pc,rw,a,b,alu,res,imm,flt,ill)",
                 t, $time, op_i, funct3_i, act, e);
      end
    end
  end

  initial begin
    do_reset();
    // ADD with no stalls
    run_instr(OP_OP, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    // LW with a three-cycle read stall
    run_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3);
    // BNE not-equal then equal
    run_instr(OP_BRANCH, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(OP_BRANCH, 3'b001, 1'b1, 1'b0, 1'b0, 0, 0);
    // JALR chain
    run_instr(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1, 0);
    // store that stalls just short of the limit
    run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 0, int'(MEM_TIMEOUT) - 1);
    // fetch that never completes
    run_instr(OP_OP, 3'b000, 1'b0, 1'b0, 1'b0, int'(MEM_TIMEOUT) + 2, 0);
    settle();
    // read that times out
    run_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 0, int'(MEM_TIMEOUT));
    settle();
    // illegal opcode
    run_instr(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    settle();
    // reserved branch funct3
    run_instr(OP_BRANCH, 3'b011, 1'b1, 1'b1, 1'b1, 0, 0);
    settle();
    run_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, 2, 0);

    for (int n = 0; n < 300; n++) begin
      run_instr(rand_op(), 3'($urandom_range(0, 7)), rbit(), rbit(), rbit(),
                rand_stall(), rand_stall());
      settle();
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15; the number of consecutive stalled cycles with mem_req_o high after which the block faults.
REQ-002 clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 op_i, input, 7 bits: instruction opcode (IR[6:0]).
REQ-005 funct3_i, input, 3 bits: IR[14:12].
REQ-006 zero_i, lt_i and ltu_i, inputs, 1 bit each: ALU flags for equal, signed less-than and unsigned less-than.
REQ-007 mem_ready_i, input, 1 bit: the memory completes the access this cycle.
REQ-008 mem_req_o, output, 1 bit: memory access request.
REQ-009 mem_write_o, output, 1 bit: the access is a store.
REQ-010 adr_src_o, output, 1 bit: memory address select; 0 = PC, 1 = ALUOut.
REQ-011 ir_write_o, pc_write_o and reg_write_o, outputs, 1 bit each: write enables for IR, PC and the register file.
REQ-012 alu_src_a_o, output, 2 bits: ALU operand A select; 00 PC, 01 oldPC, 10 rs1, 11 zero.
REQ-013 alu_src_b_o, output, 2 bits: ALU operand B select; 00 rs2, 01 imm, 10 constant 4.
REQ-014 alu_op_o, output, 2 bits: 00 add, 01 subtract/compare, 10 decode from funct fields.
REQ-015 result_src_o, output, 2 bits: result select; 00 ALUOut, 01 memory read data, 10 ALU result.
REQ-016 imm_src_o, output, 3 bits: immediate format select; 000 I, 001 B, 010 S, 011 U, 100 J.
REQ-017 fault_o and illegal_o, outputs, 1 bit each: sticky error flags.

Function
REQ-018 The state set SHALL be: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JALR, JAL, UPPER, HALT.
REQ-019 Outputs SHALL be Moore-type except pc_write_o and ir_write_o in FETCH and pc_write_o in BRANCH; unlisted outputs are 0 in every state.
REQ-020 imm_src_o SHALL decode combinationally from op_i in all states:
- LOAD, OP-IMM, JALR -> 000
- STORE -> 010
- BRANCH -> 001
- LUI, AUIPC -> 011
- JAL -> 100
- any other opcode -> 000
REQ-021 FETCH: mem_req_o=1, adr_src_o=0, a=00, b=10, alu_op=00, result_src=10. ir_write_o and pc_write_o SHALL equal mem_ready_i. The block SHALL go to DECODE when mem_ready_i=1 and hold otherwise.
REQ-022 DECODE: a=01, b=01, alu_op=00, so ALUOut receives oldPC+imm. Next state by opcode:
- LOAD/STORE -> MEMADR
- OP -> EXEC_R
- OP-IMM -> EXEC_I
- BRANCH -> BRANCH
- JAL -> JAL
- JALR -> JALR
- LUI/AUIPC -> UPPER
- other opcode -> HALT with illegal_o set
REQ-023 MEMADR: a=10, b=01, alu_op=00. Next state is MEMREAD for LOAD and MEMWRITE for STORE.
REQ-024 MEMREAD: mem_req_o=1, adr_src_o=1; advance to MEMWB on mem_ready_i. MEMWB: result_src=01, reg_write_o=1; next state FETCH.
REQ-025 MEMWRITE: mem_req_o=1, mem_write_o=1, adr_src_o=1; advance to FETCH on mem_ready_i.
REQ-026 EXEC_R: a=10, b=00, alu_op=10. EXEC_I: a=10, b=01, alu_op=10. Both go to ALUWB.
REQ-027 UPPER: b=01, alu_op=00, a=11 for LUI and a=01 for AUIPC; next state ALUWB.
REQ-028 ALUWB: result_src=00, reg_write_o=1; next state FETCH.
REQ-029 BRANCH: a=10, b=00, alu_op=01, result_src=00. pc_write_o = taken, where taken by funct3 is:
- 000 zero_i; 001 !zero_i
- 100 lt_i; 101 !lt_i
- 110 ltu_i; 111 !ltu_i
Next state is FETCH. funct3 010 or 011 SHALL set illegal_o and go to HALT with pc_write_o=0.
REQ-030 JALR: a=10, b=01, alu_op=00 (ALUOut gets rs1+imm); next state JAL.
REQ-031 JAL: a=01, b=10, alu_op=00, result_src=00, pc_write_o=1; next state ALUWB, which writes rd=oldPC+4.
REQ-032 The wait counter (width ceil(log2(MEM_TIMEOUT+1))):
- increments each cycle mem_req_o=1 and mem_ready_i=0
- clears on mem_ready_i=1 and on any state change
- on reaching MEM_TIMEOUT, the next state is HALT and fault_o is set
REQ-033 HALT: all enables and mem_req_o are 0. The block leaves HALT only on reset; fault_o and illegal_o hold until reset.

Reset
REQ-034 On rst_i=1 at a clock edge the block SHALL enter FETCH, clear the counter, fault_o and illegal_o, and override any in-progress memory wait.
REQ-035 During reset all write enables SHALL be 0.

Verification
REQ-036 ADD (op 0110011), ready every cycle -> FETCH, DECODE, EXEC_R, ALUWB, FETCH; reg_write_o=1 only in the 4th cycle.
REQ-037 LW with mem_ready_i low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, reg_write_o=1 once in MEMWB, fault_o=0.
REQ-038 BNE (funct3 001): zero_i=0 -> pc_write_o=1 in BRANCH; zero_i=1 -> pc_write_o=0.
REQ-039 JALR -> JALR, JAL (pc_write_o=1), ALUWB (reg_write_o=1); imm_src_o=000 throughout.
REQ-040 mem_ready_i held 0 in FETCH with MEM_TIMEOUT=15 -> HALT after 15 stall cycles, fault_o=1; rst_i pulse -> FETCH, fault_o=0.
REQ-041 Opcode 1111111 -> DECODE then HALT, illegal_o=1, no write enable ever asserted afterwards.
